// File: rtl/switch_pkg.sv
// switch_pkg
//   Shared constants and types for the switch conditioning front end.
//   No ports; imported by debounce_bit and switch_conditioner.
//   Contents:
//     NUM_SW_DEF           default number of switch channels
//     CLK_HZ               system clock frequency
//     DEBOUNCE_CYCLES_10MS 10 ms debounce window expressed in CLK_HZ cycles
//     db_state_t           per-channel debounce state

package switch_pkg;

   localparam int unsigned NUM_SW_DEF           = 4;
   localparam int unsigned CLK_HZ               = 125_000_000;
   localparam int unsigned DEBOUNCE_CYCLES_10MS = CLK_HZ / 100;

   typedef enum logic {
      ST_STABLE   = 1'b0,
      ST_CHANGING = 1'b1
   } db_state_t;

endpackage : switch_pkg

// File: rtl/debounce_bit.sv
// debounce_bit
//   One switch channel: 2-flop synchronizer, debounce FSM with window counter,
//   and registered rise/fall pulses aligned with the level update.
//   Ports:
//     clk     in   system clock
//     reset   in   synchronous active-high reset
//     sw_raw  in   asynchronous raw switch level
//     level   out  debounced level
//     rise    out  one-cycle pulse when level goes 0->1
//     fall    out  one-cycle pulse when level goes 1->0
//
//   state       | meaning
//   ------------+------------------------------------------------------------
//   ST_STABLE   | synced input matches level, counter held at 0
//   ST_CHANGING | synced input differs from level, counter measures how long

module debounce_bit
   import switch_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_10MS,
   parameter int unsigned CNT_W           = 24
) (
   input  logic clk,
   input  logic reset,
   input  logic sw_raw,
   output logic level,
   output logic rise,
   output logic fall
);

   localparam logic [CNT_W-1:0] CNT_TC  = CNT_W'(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   if (DEBOUNCE_CYCLES < 2) begin : g_chk_min
      $error("debounce_bit: DEBOUNCE_CYCLES must be at least 2");
   end
   if ((64'd1 << CNT_W) <= 64'(DEBOUNCE_CYCLES)) begin : g_chk_width
      $error("debounce_bit: CNT_W too narrow for DEBOUNCE_CYCLES");
   end

   logic [1:0]       sync_q;
   logic             sw_sync;
   db_state_t        state;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= 2'b00;
      end else begin
         sync_q <= {sync_q[0], sw_raw};
      end
   end

   assign sw_sync = sync_q[1];

   // The counter records how many consecutive edges the new value has been
   // seen; acceptance happens on the edge after it reaches the window length,
   // provided the input still differs, giving 2 + DEBOUNCE_CYCLES total latency.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_STABLE;
         cnt   <= '0;
         level <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         rise <= 1'b0;
         fall <= 1'b0;
         case (state)
            ST_STABLE: begin
               cnt <= '0;
               if (sw_sync != level) begin
                  state <= ST_CHANGING;
                  cnt   <= CNT_ONE;
               end
            end
            ST_CHANGING: begin
               if (sw_sync == level) begin
                  state <= ST_STABLE;
                  cnt   <= '0;
               end else if (cnt == CNT_TC) begin
                  level <= sw_sync;
                  rise  <= sw_sync;
                  fall  <= ~sw_sync;
                  cnt   <= '0;
                  state <= ST_STABLE;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            default: begin
               state <= ST_STABLE;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule : debounce_bit

// File: rtl/switch_conditioner.sv
// switch_conditioner
//   Input stage for the game: turns the raw board slide switches into
//   synchronized, debounced levels with single-cycle edge pulses, plus a settle
//   flag that rises once the first debounce window after reset has elapsed.
//   Optional feature macro: SWCOND_TOGGLE_EN adds a press-to-toggle output.
//   Ports:
//     clk        in   system clock
//     reset      in   synchronous active-high reset
//     sw_raw     in   [NUM_SW] asynchronous raw switch levels
//     sw_level   out  [NUM_SW] debounced levels
//     sw_rise    out  [NUM_SW] one-cycle pulse on level 0->1
//     sw_fall    out  [NUM_SW] one-cycle pulse on level 1->0
//     sw_valid   out  high once the first post-reset window has elapsed
//     sw_toggle  out  [NUM_SW] flips on each sw_rise (SWCOND_TOGGLE_EN only)

module switch_conditioner
   import switch_pkg::*;
#(
   parameter int unsigned NUM_SW          = NUM_SW_DEF,
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_10MS,
   parameter int unsigned CNT_W           = 24
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NUM_SW-1:0] sw_raw,
   output logic [NUM_SW-1:0] sw_level,
   output logic [NUM_SW-1:0] sw_rise,
   output logic [NUM_SW-1:0] sw_fall,
`ifdef SWCOND_TOGGLE_EN
   output logic [NUM_SW-1:0] sw_toggle,
`endif
   output logic              sw_valid
);

   // One extra bit so the settle target (window + 2) never wraps even when
   // DEBOUNCE_CYCLES sits at the top of the counter range.
   localparam int unsigned          SETTLE_W   = CNT_W + 1;
   localparam logic [SETTLE_W-1:0]  SETTLE_TC  = SETTLE_W'(DEBOUNCE_CYCLES + 2);
   localparam logic [SETTLE_W-1:0]  SETTLE_ONE = SETTLE_W'(1);

   logic [SETTLE_W-1:0] settle_cnt;

   for (genvar i = 0; i < NUM_SW; i++) begin : g_ch
      debounce_bit #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W)
      ) u_db (
         .clk    (clk),
         .reset  (reset),
         .sw_raw (sw_raw[i]),
         .level  (sw_level[i]),
         .rise   (sw_rise[i]),
         .fall   (sw_fall[i])
      );
   end

   // Counts DEBOUNCE_CYCLES+2 clocks after reset release; sw_valid rises on the
   // same edge a switch held high through reset first shows on sw_level.
   always_ff @(posedge clk) begin
      if (reset) begin
         settle_cnt <= '0;
         sw_valid   <= 1'b0;
      end else if (!sw_valid) begin
         if (settle_cnt == SETTLE_TC) begin
            sw_valid <= 1'b1;
         end else begin
            settle_cnt <= settle_cnt + SETTLE_ONE;
         end
      end
   end

`ifdef SWCOND_TOGGLE_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         sw_toggle <= '0;
      end else begin
         sw_toggle <= sw_toggle ^ sw_rise;
      end
   end
`endif

endmodule : switch_conditioner

// File: tb/tb_switch_conditioner.sv
module tb_switch_conditioner;

   localparam int NSW = 4;
   localparam int DB  = 4;

   logic           clk = 1'b0;
   logic           reset;
   logic [NSW-1:0] sw_raw;
   logic [NSW-1:0] sw_level, sw_rise, sw_fall;
   logic           sw_valid;
`ifdef SWCOND_TOGGLE_EN
   logic [NSW-1:0] sw_toggle;
`endif

   switch_conditioner #(
      .NUM_SW          (NSW),
      .DEBOUNCE_CYCLES (DB),
      .CNT_W           (3)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .sw_raw    (sw_raw),
      .sw_level  (sw_level),
      .sw_rise   (sw_rise),
      .sw_fall   (sw_fall),
`ifdef SWCOND_TOGGLE_EN
      .sw_toggle (sw_toggle),
`endif
      .sw_valid  (sw_valid)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: a new level is accepted on edge n when the synchronized
   // input (raw sampled two edges earlier) has disagreed with the current
   // level on every one of the last DB+1 edges since reset release.
   logic [NSW-1:0] hist[$];
   int             edge_n;
   logic [NSW-1:0] m_level, m_rise, m_fall, m_toggle;
   logic           m_valid;

   task automatic model_reset();
      hist.delete();
      edge_n   = 0;
      m_level  = '0;
      m_rise   = '0;
      m_fall   = '0;
      m_toggle = '0;
      m_valid  = 1'b0;
   endtask

   task automatic model_edge(input logic [NSW-1:0] raw);
      m_toggle = m_toggle ^ m_rise;
      hist.push_back(raw);
      m_rise = '0;
      m_fall = '0;
      for (int i = 0; i < NSW; i++) begin
         bit flip;
         flip = (edge_n - DB >= 2);
         for (int j = edge_n - DB; j <= edge_n; j++)
            if (flip && hist[j-2][i] == m_level[i]) flip = 1'b0;
         if (flip) begin
            if (m_level[i]) m_fall[i] = 1'b1;
            else            m_rise[i] = 1'b1;
            m_level[i] = ~m_level[i];
         end
      end
      if (edge_n >= DB + 2) m_valid = 1'b1;
      edge_n++;
   endtask

   task automatic tick(input logic rst, input logic [NSW-1:0] raw);
      reset  = rst;
      sw_raw = raw;
      @(posedge clk);
      if (rst) model_reset();
      else     model_edge(raw);
      #1;
   endtask

   task automatic test_reset();
      for (int k = 0; k < 3; k++) begin
         tick(1'b1, 4'b1010);
         n_cmp++;
         if ({sw_level, sw_rise, sw_fall, sw_valid} !== 13'd0) begin
            n_bad++;
            $display("FAIL reset_hold k=%0d got lvl=%b rise=%b fall=%b vld=%b want all 0",
                     k, sw_level, sw_rise, sw_fall, sw_valid);
         end
      end
      for (int k = 0; k < 10; k++) begin
         tick(1'b0, 4'b1010);
         n_cmp++;
         if ({sw_level, sw_rise, sw_fall, sw_valid} !== {m_level, m_rise, m_fall, m_valid}) begin
            n_bad++;
            $display("FAIL reset_release k=%0d got %b/%b/%b/%b want %b/%b/%b/%b", k,
                     sw_level, sw_rise, sw_fall, sw_valid, m_level, m_rise, m_fall, m_valid);
         end
         if (k == 5) begin
            n_cmp++;
            if (sw_valid !== 1'b0 || sw_level !== 4'b0000) begin
               n_bad++;
               $display("FAIL powerup_early got vld=%b lvl=%b want 0/0000", sw_valid, sw_level);
            end
         end
         if (k == 6) begin
            n_cmp++;
            if (sw_valid !== 1'b1 || sw_level !== 4'b1010 || sw_rise !== 4'b1010) begin
               n_bad++;
               $display("FAIL powerup_clk6 got vld=%b lvl=%b rise=%b want 1/1010/1010",
                        sw_valid, sw_level, sw_rise);
            end
         end
         if (k == 7) begin
            n_cmp++;
            if (sw_rise !== 4'b0000) begin
               n_bad++;
               $display("FAIL powerup_pulse_width got rise=%b want 0000", sw_rise);
            end
         end
      end
   endtask

   task automatic test_clean_step();
      for (int k = 0; k < 10; k++) begin
         tick(1'b0, 4'b1011);
         n_cmp++;
         if ({sw_level, sw_rise, sw_fall} !== {m_level, m_rise, m_fall}) begin
            n_bad++;
            $display("FAIL clean_step k=%0d got %b/%b/%b want %b/%b/%b", k,
                     sw_level, sw_rise, sw_fall, m_level, m_rise, m_fall);
         end
         n_cmp++;
         if (sw_level[0] !== (k >= 6) || sw_rise[0] !== (k == 6) || sw_fall !== 4'b0000) begin
            n_bad++;
            $display("FAIL clean_step_timing k=%0d got lvl0=%b rise0=%b fall=%b want %b/%b/0000",
                     k, sw_level[0], sw_rise[0], sw_fall, k >= 6, k == 6);
         end
      end
   endtask

   task automatic test_bounce();
      logic [3:0] seq [4] = '{4'b1111, 4'b1011, 4'b1111, 4'b1011};
      int rises = 0;
      int rise_at = -1;
      for (int k = 0; k < 16; k++) begin
         tick(1'b0, (k < 4) ? seq[k] : 4'b1111);
         if (sw_rise[2]) begin
            rises++;
            rise_at = k;
         end
         n_cmp++;
         if ({sw_level, sw_rise, sw_fall} !== {m_level, m_rise, m_fall}) begin
            n_bad++;
            $display("FAIL bounce k=%0d got %b/%b/%b want %b/%b/%b", k,
                     sw_level, sw_rise, sw_fall, m_level, m_rise, m_fall);
         end
         if (k < 10) begin
            n_cmp++;
            if (sw_level[2] !== 1'b0) begin
               n_bad++;
               $display("FAIL bounce_hold k=%0d got lvl2=%b want 0", k, sw_level[2]);
            end
         end
      end
      n_cmp++;
      if (rises != 1 || rise_at != 10) begin
         n_bad++;
         $display("FAIL bounce_single_rise got count=%0d at=%0d want 1 at 10", rises, rise_at);
      end
   endtask

   task automatic test_simultaneous();
      logic [3:0] targets [3] = '{4'b0000, 4'b1111, 4'b0000};
      for (int p = 0; p < 3; p++) begin
         int full = 0;
         int partial = 0;
         for (int k = 0; k < 9; k++) begin
            tick(1'b0, targets[p]);
            if (p > 0) begin
               if ((p == 1 ? sw_rise : sw_fall) == 4'b1111) full++;
               else if ((p == 1 ? sw_rise : sw_fall) != 4'b0000) partial++;
            end
            n_cmp++;
            if ({sw_level, sw_rise, sw_fall} !== {m_level, m_rise, m_fall}) begin
               n_bad++;
               $display("FAIL simultaneous p=%0d k=%0d got %b/%b/%b want %b/%b/%b", p, k,
                        sw_level, sw_rise, sw_fall, m_level, m_rise, m_fall);
            end
         end
         if (p > 0) begin
            n_cmp++;
            if (full != 1 || partial != 0) begin
               n_bad++;
               $display("FAIL simultaneous_pulse p=%0d got full=%0d partial=%0d want 1/0",
                        p, full, partial);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      tick(1'b0, 4'b0010);
      tick(1'b0, 4'b0010);
      tick(1'b1, 4'b0010);
      n_cmp++;
      if ({sw_level, sw_rise, sw_fall, sw_valid} !== 13'd0) begin
         n_bad++;
         $display("FAIL reset_mid got lvl=%b rise=%b fall=%b vld=%b want all 0",
                  sw_level, sw_rise, sw_fall, sw_valid);
      end
      for (int k = 0; k < 10; k++) begin
         tick(1'b0, 4'b0010);
         n_cmp++;
         if ({sw_level, sw_rise, sw_fall, sw_valid} !== {m_level, m_rise, m_fall, m_valid}) begin
            n_bad++;
            $display("FAIL reset_mid_after k=%0d got %b/%b/%b/%b want %b/%b/%b/%b", k,
                     sw_level, sw_rise, sw_fall, sw_valid, m_level, m_rise, m_fall, m_valid);
         end
         n_cmp++;
         if (sw_level[1] !== (k >= 6) || sw_rise[1] !== (k == 6)) begin
            n_bad++;
            $display("FAIL reset_mid_window k=%0d got lvl1=%b rise1=%b want %b/%b",
                     k, sw_level[1], sw_rise[1], k >= 6, k == 6);
         end
      end
   endtask

   task automatic test_random();
      logic [NSW-1:0] raw = sw_raw;
      for (int k = 0; k < 800; k++) begin
         int odds = (k < 400) ? 3 : 9;
         for (int i = 0; i < NSW; i++)
            if ($urandom_range(0, odds) == 0) raw[i] = ~raw[i];
         tick(1'b0, raw);
         n_cmp++;
         if ({sw_level, sw_rise, sw_fall, sw_valid} !== {m_level, m_rise, m_fall, m_valid}
             || (sw_rise & sw_fall) !== 4'b0000) begin
            n_bad++;
            $display("FAIL random k=%0d raw=%b got %b/%b/%b/%b want %b/%b/%b/%b", k, raw,
                     sw_level, sw_rise, sw_fall, sw_valid, m_level, m_rise, m_fall, m_valid);
         end
      end
   endtask

`ifdef SWCOND_TOGGLE_EN
   task automatic test_toggle();
      logic [3:0] pattern [4] = '{4'b1000, 4'b0000, 4'b1000, 4'b0000};
      int presses = 0;
      logic prev_rise;
      tick(1'b1, 4'b0000);
      for (int k = 0; k < 8; k++) tick(1'b0, 4'b0000);
      for (int p = 0; p < 4; p++) begin
         for (int k = 0; k < 9; k++) begin
            prev_rise = sw_rise[3];
            tick(1'b0, pattern[p]);
            n_cmp++;
            if (sw_toggle !== m_toggle) begin
               n_bad++;
               $display("FAIL toggle p=%0d k=%0d got %b want %b", p, k, sw_toggle, m_toggle);
            end
            if (prev_rise) begin
               presses++;
               n_cmp++;
               if (sw_toggle[3] !== presses[0]) begin
                  n_bad++;
                  $display("FAIL toggle_after_rise press=%0d got %b want %b",
                           presses, sw_toggle[3], presses[0]);
               end
            end
         end
      end
      n_cmp++;
      if (presses != 2 || sw_toggle[3] !== 1'b0) begin
         n_bad++;
         $display("FAIL toggle_presses got %0d final=%b want 2/0", presses, sw_toggle[3]);
      end
   endtask
`endif

   initial begin
      reset  = 1'b1;
      sw_raw = '0;
      model_reset();
      test_reset();
      test_clean_step();
      test_bounce();
      test_simultaneous();
      test_reset_mid();
      test_random();
`ifdef SWCOND_TOGGLE_EN
      test_toggle();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_switch_conditioner
